// File: rtl/tiny_cu_if.sv
// Instruction and data memory handshake bundle for the TinyCPU control unit.
interface tiny_cu_if #(
    parameter int PC_BITS = 8
);
    logic               imem_req;
    logic [PC_BITS-1:0] imem_addr;
    logic               imem_ack;
    logic [15:0]        imem_data;
    logic               dmem_req;
    logic               dmem_we;
    logic               dmem_ack;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we,
        input  imem_ack, imem_data, dmem_ack
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we,
        output imem_ack, imem_data, dmem_ack
    );
endinterface

// File: rtl/tiny_control_unit.sv
// Hardwired fetch/exec/mem sequencer for the TinyCPU datapath; decodes IR into
// datapath selects and keeps the branch flags from the last ALU/shift op.
module tiny_control_unit #(
    parameter int BITS    = 16,
    parameter int PC_BITS = 8
) (
    input  logic            clk,
    input  logic            rst,
    tiny_cu_if.master       bus,
    output logic            LoadEnable,
    output logic [1:0]      ASelect,
    output logic [1:0]      BSelect,
    output logic [1:0]      DestinationSelect,
    output logic [BITS-1:0] ConstantIn,
    output logic            MBSelect,
    output logic            MDSelect,
    output logic [3:0]      GSelect,
    output logic [1:0]      HSelect,
    output logic            MFSelect,
    input  logic            statC,
    input  logic            statV,
    input  logic            statN,
    input  logic            statZ,
    output logic            halted
);
    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

    localparam logic [3:0] OP_ADD  = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3,
                           OP_OR   = 4'h4, OP_XOR = 4'h5, OP_ADDI = 4'h6,
                           OP_LD   = 4'h8, OP_ST  = 4'h9, OP_SHL = 4'hA,
                           OP_SHR  = 4'hB, OP_BZ  = 4'hC, OP_BN  = 4'hD,
                           OP_JMP  = 4'hE, OP_HALT = 4'hF;

    state_t             state_q;
    logic [PC_BITS-1:0] pc_q, pc_d;
    logic [15:0]        ir_q;
    logic               c_q, v_q, n_q, z_q;
    logic               halted_q;

    logic [3:0]         op;
    logic               is_alu, taken;
    logic [PC_BITS-1:0] pc_inc, simm_pc;

    assign op      = ir_q[15:12];
    assign is_alu  = (op >= OP_ADD && op <= OP_ADDI) || op == OP_SHL || op == OP_SHR;
    assign taken   = (op == OP_BZ && z_q) || (op == OP_BN && n_q) || (op == OP_JMP);
    assign pc_inc  = pc_q + PC_BITS'(1);
    assign simm_pc = {{(PC_BITS-6){ir_q[5]}}, ir_q[5:0]};
    assign pc_d    = taken ? pc_inc + simm_pc : pc_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FETCH;
            pc_q     <= '0;
            ir_q     <= '0;
            {c_q, v_q, n_q, z_q} <= '0;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: if (bus.imem_ack) begin
                    ir_q    <= bus.imem_data;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    if (is_alu) {c_q, v_q, n_q, z_q} <= {statC, statV, statN, statZ};
                    case (op)
                        OP_LD, OP_ST: state_q <= S_MEM;
                        OP_HALT: begin
                            state_q  <= S_HALT;
                            halted_q <= 1'b1;
                        end
                        default: begin
                            pc_q    <= pc_d;
                            state_q <= S_FETCH;
                        end
                    endcase
                end
                S_MEM: if (bus.dmem_ack) begin
                    pc_q    <= pc_inc;
                    state_q <= S_FETCH;
                end
                default: state_q <= S_HALT;
            endcase
        end
    end

    // Every output is forced low while rst is high so an abandoned access cannot write.
    logic active;
    assign active = !rst && (state_q == S_EXEC || state_q == S_MEM);

    always_comb begin
        ASelect           = '0;
        BSelect           = '0;
        DestinationSelect = '0;
        ConstantIn        = '0;
        MBSelect          = 1'b0;
        MDSelect          = 1'b0;
        GSelect           = '0;
        HSelect           = '0;
        MFSelect          = 1'b0;
        if (active) begin
            ASelect           = ir_q[9:8];
            BSelect           = ir_q[7:6];
            DestinationSelect = ir_q[11:10];
            case (op)
                OP_ADD: GSelect = 4'b0010;
                OP_SUB: GSelect = 4'b0101;
                OP_AND: GSelect = 4'b1000;
                OP_OR:  GSelect = 4'b1010;
                OP_XOR: GSelect = 4'b1100;
                OP_ADDI: begin
                    GSelect    = 4'b0010;
                    MBSelect   = 1'b1;
                    ConstantIn = {{(BITS-6){ir_q[5]}}, ir_q[5:0]};
                end
                OP_LD:  MDSelect = 1'b1;
                OP_SHL: begin
                    HSelect  = 2'b10;
                    MFSelect = 1'b1;
                end
                OP_SHR: begin
                    HSelect  = 2'b01;
                    MFSelect = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign LoadEnable = !rst && ((state_q == S_EXEC && is_alu) ||
                                 (state_q == S_MEM && op == OP_LD && bus.dmem_ack));
    assign bus.dmem_req  = !rst && state_q == S_MEM;
    assign bus.dmem_we   = bus.dmem_req && op == OP_ST;
    assign bus.imem_req  = !rst && state_q == S_FETCH;
    assign bus.imem_addr = rst ? '0 : pc_q;
    assign halted        = !rst && halted_q;
endmodule
